// File: rtl/inst_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding and
// the opcode constants carried in the top two bits of an instruction word.
package inst_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_ISSUE = 3'd2,
      ST_GAP   = 3'd3,
      ST_HOLD  = 3'd4,
      ST_DONE  = 3'd5
   } seqState_t;

   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_MULT = 2'b10;
   localparam logic [1:0] OP_SEND = 2'b11;

endpackage

// File: rtl/inst_ram.sv
// Instruction store: one synchronous write port and one synchronous
// read-first read port. The array itself is never reset; only the read
// data register is cleared so the instruction output starts at zero.
module inst_ram #(
   parameter int INST_W = 8,
   parameter int DEPTH  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_wrEn,
   input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
   input  logic [INST_W-1:0]        i_wrData,
   input  logic                     i_rdEn,
   input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
   output logic [INST_W-1:0]        o_rdData
);

   logic [INST_W-1:0] r_mem [DEPTH];

   // Write port: commits the word at the clock edge regardless of sequencer state
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
   end

   // Read port: samples the array before this edge's write lands, so a same-cycle write returns old data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_rdData <= '0;
      end else if (i_rdEn) begin
         o_rdData <= r_mem[i_rdAddr];
      end
   end

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: plays a programmed list of instruction words to a
// valid/ready consumer, with optional idle gap, single-step and looping.
module inst_sequencer
   import inst_pkg::*;
#(
   parameter int INST_W = 8,
   parameter int DEPTH  = 32,
   parameter int GAP    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [INST_W-1:0]        wr_data,
   input  logic [$clog2(DEPTH):0]   len,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     step_mode,
   input  logic                     step,
   input  logic                     loop_en,
   input  logic                     inst_rdy,
   output logic                     inst_vld,
   output logic [INST_W-1:0]        inst_wd,
   output logic [$clog2(DEPTH)-1:0] pc,
   output logic                     busy,
   output logic                     done
);

   localparam int AW = $clog2(DEPTH);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);
   localparam logic [AW-1:0] PC_ONE   = AW'(1);
   localparam logic [AW:0]   LEN_ONE  = (AW + 1)'(1);

   seqState_t         r_state;
   logic [AW-1:0]     r_pc;
   logic [GW-1:0]     r_gapCnt;
   logic              r_vld;
   logic              r_busy;
   logic              r_done;
   logic              w_isLast;
   logic              w_rdEn;

   // len is compared live so software may change it while a program runs
   assign w_isLast = ({1'b0, r_pc} == (len - LEN_ONE));
   assign w_rdEn   = (r_state == ST_FETCH);

   inst_ram #(
      .INST_W(INST_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wrEn  (wr_en),
      .i_wrAddr(wr_addr),
      .i_wrData(wr_data),
      .i_rdEn  (w_rdEn),
      .i_rdAddr(r_pc),
      .o_rdData(inst_wd)
   );

   // Sequencing FSM with registered handshake/status outputs; abort overrides everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_pc     <= '0;
         r_gapCnt <= '0;
         r_vld    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else if (abort) begin
         r_state  <= ST_IDLE;
         r_gapCnt <= '0;
         r_vld    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start && (len != '0)) begin
                  r_pc    <= '0;
                  r_state <= ST_FETCH;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            ST_FETCH: begin
               r_state <= ST_ISSUE;
               r_vld   <= 1'b1;
            end
            ST_ISSUE: begin
               if (inst_rdy) begin
                  r_vld <= 1'b0;
                  if (w_isLast && !loop_en) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_pc <= w_isLast ? '0 : (r_pc + PC_ONE);
                     if (step_mode) begin
                        r_state <= ST_HOLD;
                     end else if (GAP > 0) begin
                        r_state  <= ST_GAP;
                        r_gapCnt <= GAP_LOAD;
                     end else begin
                        r_state <= ST_FETCH;
                     end
                  end
               end
            end
            ST_GAP: begin
               if (r_gapCnt == '0) begin
                  r_state <= ST_FETCH;
               end else begin
                  r_gapCnt <= r_gapCnt - GAP_ONE;
               end
            end
            ST_HOLD: begin
               if (step) begin
                  r_state <= ST_FETCH;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign inst_vld = r_vld;
   assign pc       = r_pc;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: stimulus pushes expected transfers
// into a scoreboard queue, a negedge monitor pops and compares each transfer.
module tb_inst_sequencer;

   localparam int INST_W = 8;
   localparam int DEPTH  = 4;
   localparam int GAP    = 4;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [2:0] len;
   logic       start;
   logic       abort;
   logic       step_mode;
   logic       step;
   logic       loop_en;
   wire        inst_rdy;
   logic       inst_vld;
   logic [7:0] inst_wd;
   logic [1:0] pc;
   logic       busy;
   logic       done;

   logic       rdyRandom;
   logic       rdyForce;
   logic       rdyRand;

   typedef struct {
      logic [7:0] wd;
      logic [1:0] idx;
   } exp_t;

   exp_t       expQ[$];
   int         xferCyc[$];
   logic [7:0] refMem[DEPTH];
   int         checks;
   int         errors;
   int         xferCount;
   int         cyc;
   logic       prevStall;
   logic       prevAbort;
   logic [7:0] prevWd;
   exp_t       monItem;

   assign inst_rdy = rdyRandom ? rdyRand : rdyForce;

   inst_sequencer #(
      .INST_W(INST_W),
      .DEPTH (DEPTH),
      .GAP   (GAP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .len      (len),
      .start    (start),
      .abort    (abort),
      .step_mode(step_mode),
      .step     (step),
      .loop_en  (loop_en),
      .inst_rdy (inst_rdy),
      .inst_vld (inst_vld),
      .inst_wd  (inst_wd),
      .pc       (pc),
      .busy     (busy),
      .done     (done)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Random backpressure source, roughly three quarters ready
   initial begin
      rdyRand = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         rdyRand = ($urandom_range(0, 3) != 0);
      end
   end

   // Hard stop in case something never settles
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeMem(input int a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a[1:0];
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      refMem[a] = d;
   endtask

   task automatic pushExp(input int idx);
      exp_t e;
      e.wd  = refMem[idx];
      e.idx = idx[1:0];
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input int lenV, input logic loopV, input logic stepV);
      len       = lenV[2:0];
      loop_en   = loopV;
      step_mode = stepV;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic waitXfers(input int n, input int budget);
      int i = 0;
      while (xferCount < n && i < budget) begin
         tick();
         i++;
      end
      checkOutput("xferWait", 32'(xferCount >= n), 1);
   endtask

   task automatic waitDone(input int budget);
      int i = 0;
      while (done !== 1'b1 && i < budget) begin
         tick();
         i++;
      end
      checkOutput("doneWait", 32'(done), 1);
   endtask

   task automatic waitVld(input int budget);
      int i = 0;
      while (inst_vld !== 1'b1 && i < budget) begin
         tick();
         i++;
      end
      checkOutput("vldWait", 32'(inst_vld), 1);
   endtask

   task automatic pulseAbort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   // Scoreboard monitor: sampled on the falling edge, checks each transfer and hold stability
   initial begin
      cyc       = 0;
      xferCount = 0;
      prevStall = 1'b0;
      prevAbort = 1'b0;
      prevWd    = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n === 1'b1) begin
            if (prevStall && !prevAbort) begin
               checkOutput("holdVld", 32'(inst_vld), 1);
               checkOutput("holdWd", 32'(inst_wd), 32'(prevWd));
            end
            if (inst_vld === 1'b1 && inst_rdy === 1'b1) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpectedXfer: got word 0x%0h at pc %0d, expected no transfer", inst_wd, pc);
               end else begin
                  monItem = expQ.pop_front();
                  checkOutput("xferWd", 32'(inst_wd), 32'(monItem.wd));
                  checkOutput("xferPc", 32'(pc), 32'(monItem.idx));
               end
               xferCount++;
               xferCyc.push_back(cyc);
            end
         end
         prevStall = (rst_n === 1'b1) && (inst_vld === 1'b1) && (inst_rdy === 1'b0);
         prevWd    = inst_wd;
         prevAbort = abort;
      end
   end

   // Main stimulus sequence
   initial begin
      int b;
      int xb;
      int lenR;
      logic [7:0] newV;
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      len       = '0;
      start     = 1'b0;
      abort     = 1'b0;
      step_mode = 1'b0;
      step      = 1'b0;
      loop_en   = 1'b0;
      rdyRandom = 1'b0;
      rdyForce  = 1'b1;

      // Reset values
      #12;
      checkOutput("rstVld", 32'(inst_vld), 0);
      checkOutput("rstWd", 32'(inst_wd), 0);
      checkOutput("rstPc", 32'(pc), 0);
      checkOutput("rstBusy", 32'(busy), 0);
      checkOutput("rstDone", 32'(done), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Basic play with full spacing
      $display("[TB] basic play");
      writeMem(0, 8'h04);
      writeMem(1, 8'h00);
      writeMem(2, 8'h13);
      for (int i = 0; i < 3; i++) pushExp(i);
      xb = xferCyc.size();
      applyStimulus(3, 1'b0, 1'b0);
      checkOutput("busyRun", 32'(busy), 1);
      waitDone(100);
      checkOutput("donePc", 32'(pc), 2);
      checkOutput("doneBusy", 32'(busy), 0);
      if (xferCyc.size() >= xb + 3) begin
         checkOutput("spacing01", 32'(xferCyc[xb+1] - xferCyc[xb]), GAP + 2);
         checkOutput("spacing12", 32'(xferCyc[xb+2] - xferCyc[xb+1]), GAP + 2);
      end else begin
         checkOutput("spacingCount", 32'(xferCyc.size() - xb), 3);
      end

      // Backpressure on the first issue
      $display("[TB] backpressure");
      for (int i = 0; i < 3; i++) pushExp(i);
      b = xferCount;
      rdyForce = 1'b0;
      applyStimulus(3, 1'b0, 1'b0);
      waitVld(10);
      for (int i = 0; i < 10; i++) tick();
      checkOutput("stallVld", 32'(inst_vld), 1);
      checkOutput("stallWd", 32'(inst_wd), 32'h04);
      checkOutput("stallNoXfer", 32'(xferCount), 32'(b));
      rdyForce = 1'b1;
      waitDone(100);
      checkOutput("stallXfers", 32'(xferCount), 32'(b + 3));

      // Asynchronous reset during ISSUE, memory retained
      $display("[TB] reset mid-issue");
      rdyForce = 1'b0;
      applyStimulus(3, 1'b0, 1'b0);
      waitVld(10);
      rst_n = 1'b0;
      #1;
      checkOutput("arstVld", 32'(inst_vld), 0);
      checkOutput("arstWd", 32'(inst_wd), 0);
      checkOutput("arstPc", 32'(pc), 0);
      checkOutput("arstBusy", 32'(busy), 0);
      checkOutput("arstDone", 32'(done), 0);
      tick();
      tick();
      rst_n = 1'b1;
      rdyForce = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) pushExp(i);
      applyStimulus(3, 1'b0, 1'b0);
      waitDone(100);

      // Step mode, read-first on the FETCH cycle, step ignored in ISSUE
      $display("[TB] step mode");
      writeMem(0, 8'($urandom));
      writeMem(1, 8'($urandom));
      writeMem(2, 8'($urandom));
      for (int i = 0; i < 3; i++) pushExp(i);
      b = xferCount;
      applyStimulus(3, 1'b0, 1'b1);
      waitXfers(b + 1, 20);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("holdNoXfer1", 32'(xferCount), 32'(b + 1));
      checkOutput("holdVldLow", 32'(inst_vld), 0);
      checkOutput("holdBusy", 32'(busy), 1);
      step = 1'b1;
      tick();
      step = 1'b0;
      newV = ~refMem[1];
      wr_en   = 1'b1;
      wr_addr = 2'd1;
      wr_data = newV;
      tick();
      wr_en = 1'b0;
      refMem[1] = newV;
      rdyForce = 1'b0;
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      tick();
      rdyForce = 1'b1;
      waitXfers(b + 2, 20);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("holdNoXfer2", 32'(xferCount), 32'(b + 2));
      step = 1'b1;
      tick();
      step = 1'b0;
      waitDone(20);
      checkOutput("stepPc", 32'(pc), 2);
      step_mode = 1'b0;

      // Ignored starts
      $display("[TB] ignored starts");
      pulseAbort();
      applyStimulus(0, 1'b0, 1'b0);
      tick();
      checkOutput("len0Busy", 32'(busy), 0);
      checkOutput("len0Done", 32'(done), 0);
      len   = 3'd3;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      tick();
      checkOutput("startAbortBusy", 32'(busy), 0);
      checkOutput("startAbortVld", 32'(inst_vld), 0);

      // Looping play then abort
      $display("[TB] loop and abort");
      writeMem(0, 8'h86);
      writeMem(1, 8'hC0);
      for (int i = 0; i < 6; i++) pushExp(i % 2);
      b = xferCount;
      applyStimulus(2, 1'b1, 1'b0);
      waitXfers(b + 6, 100);
      pulseAbort();
      checkOutput("abortVld", 32'(inst_vld), 0);
      checkOutput("abortBusy", 32'(busy), 0);
      checkOutput("abortQ", 32'(expQ.size()), 0);
      loop_en = 1'b0;

      // Full-depth wrap with rewrite during GAP
      $display("[TB] wrap and rewrite");
      for (int i = 0; i < 4; i++) writeMem(i, 8'($urandom));
      for (int i = 0; i < 4; i++) pushExp(i);
      b = xferCount;
      applyStimulus(4, 1'b1, 1'b0);
      waitXfers(b + 4, 100);
      checkOutput("wrapPc", 32'(pc), 0);
      writeMem(1, ~refMem[1]);
      pushExp(0);
      pushExp(1);
      waitXfers(b + 6, 100);
      pulseAbort();
      checkOutput("wrapAbortVld", 32'(inst_vld), 0);
      checkOutput("wrapQ", 32'(expQ.size()), 0);
      loop_en = 1'b0;

      // Randomized runs with random backpressure
      $display("[TB] random runs");
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 4; i++) writeMem(i, 8'($urandom));
         lenR = $urandom_range(1, 4);
         for (int i = 0; i < lenR; i++) pushExp(i);
         rdyRandom = 1'b1;
         applyStimulus(lenR, 1'b0, 1'b0);
         waitDone(500);
         rdyRandom = 1'b0;
         checkOutput("rndPc", 32'(pc), 32'(lenR - 1));
         checkOutput("rndBusy", 32'(busy), 0);
         checkOutput("rndQ", 32'(expQ.size()), 0);
      end

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
